// File: rtl/trigger_pattern_gen.sv
// Circular trigger-pattern shifter: rotates a loaded pattern out serially on a
// bit-rate strobe, for a programmed number of rotations or continuously.
module trigger_pattern_gen #(
  parameter int WIDTH     = 10,
  parameter int CNT_W     = 16,
  parameter int INVERT    = 1,
  parameter int LSB_FIRST = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_pattern_in,
  input  logic [CNT_W-1:0] i_repeat_in,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_tick,
  output logic             o_data_out,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_frame
);

  localparam int   BW    = $clog2(WIDTH);
  localparam logic L_INV = (INVERT != 0);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_shadow, r_pat, w_rot;
  logic [BW-1:0]    r_bit_cnt;
  logic [CNT_W-1:0] r_rot_cnt, r_rep;
  logic             r_done;
  logic             w_go, w_wrap, w_last, w_bit;

  // stop always wins over start and over the final tick of a rotation
  assign w_go   = (r_state == S_IDLE) && i_start && !i_stop;
  assign w_wrap = (r_state == S_RUN) && i_tick && !i_stop && (r_bit_cnt == BW'(WIDTH-1));
  assign w_last = w_wrap && (r_rep != '0) && ((r_rot_cnt + CNT_W'(1)) == r_rep);

  generate
    if (LSB_FIRST != 0) begin : g_lsb
      assign w_rot = {r_pat[0], r_pat[WIDTH-1:1]};
      assign w_bit = r_pat[0];
    end else begin : g_msb
      assign w_rot = {r_pat[WIDTH-2:0], r_pat[WIDTH-1]};
      assign w_bit = r_pat[WIDTH-1];
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_go) w_next = S_RUN;
      S_RUN:   if (i_stop || w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy     = (r_state == S_RUN);
    o_frame    = o_busy && (r_bit_cnt == '0);
    o_data_out = o_busy ? (w_bit ^ L_INV) : L_INV;
    o_done     = r_done;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shadow  <= '0;
      r_pat     <= '0;
      r_rep     <= '0;
      r_bit_cnt <= '0;
      r_rot_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_last;
      case (r_state)
        S_IDLE: begin
          if (i_load) begin
            r_shadow <= i_pattern_in;
            r_pat    <= i_pattern_in;
            r_rep    <= i_repeat_in;
          end
          // a same-cycle load must feed the run directly, shadow is not yet updated
          if (w_go) begin
            r_bit_cnt <= '0;
            r_rot_cnt <= '0;
            r_pat     <= i_load ? i_pattern_in : r_shadow;
          end
        end
        S_RUN: begin
          if (i_stop) begin
            r_pat     <= r_shadow;
            r_bit_cnt <= '0;
            r_rot_cnt <= '0;
          end else if (i_tick) begin
            r_pat <= w_last ? r_shadow : w_rot;
            if (w_wrap) begin
              r_bit_cnt <= '0;
              r_rot_cnt <= r_rot_cnt + CNT_W'(1);
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_pattern_gen.sv
// Scoreboard bench for trigger_pattern_gen: expected {done,frame,busy,data_out}
// is queued as each cycle is driven and compared once the clock edge has acted.
module tb_trigger_pattern_gen;

  logic       clk = 1'b0;
  logic       rst, ld, st, sp, tk;
  logic [9:0] pin;
  logic [15:0] rin;
  logic d0_dout, d0_busy, d0_done, d0_frame;
  logic d1_dout, d1_busy, d1_done, d1_frame;

  int checks   = 0;
  int failures = 0;

  logic [9:0] cur_pat;
  logic       cur_inv, cur_lsb, cur_sel;
  logic [4:0] exp_q[$];
  string      tag_q[$];

  always #5 clk = ~clk;

  trigger_pattern_gen #(.WIDTH(10), .CNT_W(16), .INVERT(1), .LSB_FIRST(1)) u_d0 (
    .i_clk(clk), .i_reset(rst), .i_load(ld), .i_pattern_in(pin), .i_repeat_in(rin),
    .i_start(st), .i_stop(sp), .i_tick(tk),
    .o_data_out(d0_dout), .o_busy(d0_busy), .o_done(d0_done), .o_frame(d0_frame));

  trigger_pattern_gen #(.WIDTH(10), .CNT_W(16), .INVERT(0), .LSB_FIRST(0)) u_d1 (
    .i_clk(clk), .i_reset(rst), .i_load(ld), .i_pattern_in(pin), .i_repeat_in(rin),
    .i_start(st), .i_stop(sp), .i_tick(tk),
    .o_data_out(d1_dout), .o_busy(d1_busy), .o_done(d1_done), .o_frame(d1_frame));

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: {done,frame,busy,dout} got %b expected %b", tag, obs, exp);
    end
  endtask

  // expected outputs while RUN presents pattern position idx
  function automatic logic [3:0] run_e(input int idx);
    int   k;
    logic b;
    k = idx % 10;
    b = cur_lsb ? cur_pat[k] : cur_pat[9-k];
    return {1'b0, (k == 0), 1'b1, b ^ cur_inv};
  endfunction

  function automatic logic [3:0] idle_e(input logic dn);
    return {dn, 2'b00, cur_inv};
  endfunction

  task automatic cyc(input int r, input int l, input int s, input int p, input int t,
                     input logic [3:0] e, input string tag);
    logic [4:0] x;
    logic [3:0] obs;
    string      tg;
    rst = (r != 0); ld = (l != 0); st = (s != 0); sp = (p != 0); tk = (t != 0);
    exp_q.push_back({cur_sel, e});
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
    x   = exp_q.pop_front();
    tg  = tag_q.pop_front();
    obs = x[4] ? {d1_done, d1_frame, d1_busy, d1_dout}
               : {d0_done, d0_frame, d0_busy, d0_dout};
    chk(tg, obs, x[3:0]);
  endtask

  // n ticks spaced spc clocks apart, starting from displayed position idx0
  task automatic ticks(input int idx0, input int n, input int spc, input int rep_n,
                       input string tag);
    int idx;
    idx = idx0;
    for (int i = 0; i < n; i++) begin
      for (int s = 1; s <= spc; s++) begin
        int tv;
        tv = (s == spc) ? 1 : 0;
        idx += tv;
        if (rep_n != 0 && idx == rep_n * 10)
          cyc(0, 0, 0, 0, tv, idle_e(1'b1), tag);
        else
          cyc(0, 0, 0, 0, tv, run_e(idx), tag);
      end
    end
  endtask

  initial begin
    rst = 1'b0; ld = 1'b0; st = 1'b0; sp = 1'b0; tk = 1'b0; pin = '0; rin = '0;
    cur_pat = '0; cur_inv = 1'b1; cur_lsb = 1'b1; cur_sel = 1'b0;

    cyc(1, 0, 0, 0, 0, 4'b0001, "reset_d0");
    cur_sel = 1'b1; cur_inv = 1'b0;
    cyc(1, 0, 0, 0, 0, 4'b0000, "reset_d1");
    cur_sel = 1'b0; cur_inv = 1'b1;

    // finite run, tick every clock, then every 4th clock
    pin = 10'b0000000101; rin = 16'd2; cur_pat = pin;
    cyc(0, 1, 0, 0, 0, idle_e(1'b0), "load");
    cyc(0, 0, 1, 0, 0, run_e(0), "start");
    ticks(0, 20, 1, 2, "fin1");
    cyc(0, 0, 0, 0, 1, idle_e(1'b0), "fin1_post");
    cyc(0, 0, 1, 0, 0, run_e(0), "start4");
    ticks(0, 20, 4, 2, "fin4");
    cyc(0, 0, 0, 0, 0, idle_e(1'b0), "fin4_post");

    // abort, blocked start, restart, continuous with ignored load/start
    rin = 16'd0;
    cyc(0, 1, 0, 0, 0, idle_e(1'b0), "load_cont");
    cyc(0, 0, 1, 0, 0, run_e(0), "start_cont");
    ticks(0, 3, 1, 0, "abort_pre");
    cyc(0, 0, 0, 1, 1, idle_e(1'b0), "abort");
    cyc(0, 0, 0, 0, 1, idle_e(1'b0), "abort_idle");
    cyc(0, 0, 1, 1, 0, idle_e(1'b0), "stop_blocks_start");
    cyc(0, 0, 1, 0, 0, run_e(0), "restart");
    ticks(0, 240, 1, 0, "cont");
    pin = 10'h3FF; rin = 16'd5;
    cyc(0, 1, 1, 0, 1, run_e(241), "load_in_run");
    ticks(241, 259, 1, 0, "cont2");
    cyc(0, 0, 0, 1, 0, idle_e(1'b0), "stop");
    cyc(0, 0, 1, 0, 0, run_e(0), "restart2");
    ticks(0, 2, 1, 0, "shadow_kept");
    cyc(1, 0, 0, 0, 1, idle_e(1'b0), "reset_in_run");
    cyc(0, 0, 0, 0, 1, idle_e(1'b0), "reset_post");

    // MSB-first, non-inverted instance with load+start in one cycle
    cur_sel = 1'b1; cur_inv = 1'b0; cur_lsb = 1'b0;
    pin = 10'b1000000001; rin = 16'd0; cur_pat = pin;
    cyc(0, 1, 1, 0, 0, run_e(0), "ldst_sym");
    ticks(0, 19, 1, 0, "msb_sym");
    cyc(0, 0, 0, 1, 0, idle_e(1'b0), "msb_stop");
    pin = 10'b1100000001; rin = 16'd2; cur_pat = pin;
    cyc(0, 1, 1, 0, 0, run_e(0), "ldst_asym");
    ticks(0, 20, 1, 2, "msb_asym");
    cyc(0, 0, 0, 0, 0, idle_e(1'b0), "msb_post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trigger_pattern_gen.md
Name: trigger_pattern_gen

Overview:
- Parametrised circular pattern shifter that generates serial trigger patterns for the power-supply trigger path.
- Successor to the fixed 10-bit rotator. Adds:
  - configurable width, shift direction and output polarity;
  - a bit-rate strobe (tick) instead of shifting every clock;
  - a rotation (repeat) counter with automatic stop, plus start/stop control;
  - status outputs busy, done and frame.
- Sits between the register/control interface, which supplies pattern_in, repeat_in and the start/stop pulses, and the trigger output pin driver.

Parameters:
- WIDTH, 10, pattern length in bits; legal values are WIDTH >= 2.
- CNT_W, 16, width of the repeat and rotation counters.
- INVERT, 1, when 1 the output is the complement of the selected pattern bit.
- LSB_FIRST, 1, when 1 rotate right and output pat[0]; when 0 rotate left and output pat[WIDTH-1].

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  capture pattern_in and repeat_in; honoured in IDLE only.
- pattern_in  in  WIDTH  pattern to transmit.
- repeat_in  in  CNT_W  number of full rotations to send; 0 means continuous.
- start  in  1  begin transmission; honoured in IDLE only.
- stop  in  1  abort transmission.
- tick  in  1  bit-rate strobe; one shift per clock in which tick=1 while in RUN.
- data_out  out  1  serial trigger output.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the programmed rotations complete.
- frame  out  1  high while the first bit of each rotation is presented.

Behaviour:
- Registers:
  - shadow[WIDTH-1:0]: copy of the loaded pattern.
  - pat[WIDTH-1:0]: working rotate register.
  - bit_cnt: 0..WIDTH-1.
  - rot_cnt[CNT_W-1:0].
  - rep[CNT_W-1:0]: captured repeat count.
  - state: one of IDLE, RUN.
- Reset, when reset=1 at a clock edge:
  - state=IDLE; shadow, pat and rep cleared to 0; counters cleared to 0.
  - busy=0, done=0, frame=0, data_out=INVERT.
  - Reset has priority over every other input, including mid-RUN; no done pulse is produced.
- Output selection:
  - bit = LSB_FIRST ? pat[0] : pat[WIDTH-1].
  - In RUN: data_out = bit XOR INVERT.
  - In IDLE: data_out = INVERT (the inactive level).
  - data_out, busy and frame are decoded combinationally from registers only; there is no input-to-output combinational path.
- IDLE state:
  - load=1: shadow <= pattern_in, pat <= pattern_in, rep <= repeat_in.
  - start=1 with stop=0: state <= RUN; bit_cnt <= 0; rot_cnt <= 0; pat <= shadow.
  - load and start in the same cycle: the newly loaded pattern is used, i.e. pat <= pattern_in.
  - The first bit appears on data_out in the cycle after start is sampled.
  - stop in IDLE: no effect, and it blocks a simultaneous start.
- RUN state:
  - load is ignored; shadow and rep are unchanged.
  - start is ignored.
  - tick=1: pat rotates one place.
    - LSB_FIRST=1: pat <= {pat[0], pat[WIDTH-1:1]}.
    - LSB_FIRST=0: pat <= {pat[WIDTH-2:0], pat[WIDTH-1]}.
    - bit_cnt increments.
  - tick=1 and bit_cnt==WIDTH-1: bit_cnt <= 0 and rot_cnt increments. At this point pat equals shadow again.
  - If rep!=0 and rot_cnt+1==rep on that same tick: state <= IDLE, done=1 for exactly one cycle (registered), and pat <= shadow.
  - rep==0: the block never terminates on its own; rot_cnt wraps modulo 2^CNT_W.
  - tick=0: all state holds; data_out is stable for any tick spacing.
  - stop=1: state <= IDLE; pat <= shadow; counters <= 0; no done pulse.
  - stop and tick in the same cycle: stop wins and no shift occurs.
  - stop and the final tick in the same cycle: stop wins and done is not pulsed.
- Flags:
  - frame = (state==RUN) && (bit_cnt==0).
  - busy = (state==RUN).

Test Plan:
- Reset: assert reset for 2 cycles, with INVERT=1 -> data_out=1, busy=0, done=0, frame=0. Then assert reset while in RUN -> IDLE on the next cycle, data_out=1, no done pulse.
- Finite run: WIDTH=10, INVERT=1, LSB_FIRST=1; load 10'b0000000101, repeat_in=2; pulse start; tick=1 every cycle.
  - data_out sequence is 0,1,0,1,1,1,1,1,1,1 and then the same 10 values again.
  - frame is high on bits 1 and 11.
  - done pulses once, one cycle after the 20th tick; busy then goes low.
- Tick spacing: same setup with tick=1 every 4th cycle -> each data_out value is held for exactly 4 clocks; done arrives after 80 clocks.
- Abort: repeat_in=0; after 3 ticks assert stop together with tick -> no 4th shift, IDLE, data_out=1, no done. Restart -> the sequence begins again from pattern bit 0.
- Continuous mode and ignored inputs: repeat_in=0, run 50 rotations -> no done, busy stays 1. A load of 10'h3FF during RUN has no effect on the output sequence.
- Direction and polarity: LSB_FIRST=0, INVERT=0, load 10'b1000000001 and start in the same cycle as load -> data_out is 1,0,0,0,0,0,0,0,0,1 and repeats.
